// File: rtl/ifetch_queue.sv
// ---------------------------------------------------------------------------
// ifetch_queue
//   Fetch front end for the pipelined ARM core. Owns the fetch PC, drives the
//   word-aligned fetch address into a combinational instruction memory, and
//   captures each returned word together with its PC into a small prefetch
//   FIFO. The FIFO head is offered to decode over a valid/ready handshake.
//   Decode stalls are absorbed by the FIFO; a branch redirect flushes it and
//   restarts fetch from the new target.
//
// Parameters
//   DEPTH     prefetch FIFO entries (power of two, 2..16)
//   RESET_PC  fetch address after reset (bits [1:0] must be zero)
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   imem_a       out  fetch byte address, bits [1:0] always 00
//   imem_rd      in   instruction word for imem_a, same cycle
//   redirect     in   flush queue and refetch from redirect_pc
//   redirect_pc  in   new fetch address, bits [1:0] ignored
//   dec_ready    in   decode accepts the head entry this cycle
//   dec_valid    out  head entry present
//   dec_instr    out  head instruction word (0 when empty)
//   dec_pc       out  head instruction address (0 when empty)
//   dec_pcplus8  out  dec_pc + 8 (8 when empty)
//   count        out  occupied entries, 0..DEPTH
// ---------------------------------------------------------------------------
module ifetch_queue #(
    parameter int unsigned  DEPTH    = 4,
    parameter logic [31:0]  RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              imem_a,
    input  logic [31:0]              imem_rd,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     dec_ready,
    output logic                     dec_valid,
    output logic [31:0]              dec_instr,
    output logic [31:0]              dec_pc,
    output logic [31:0]              dec_pcplus8,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned   PW     = $clog2(DEPTH);
    localparam int unsigned   CW     = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    // Fetch state
    logic [31:0]   r_pc;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Prefetch storage: instruction word and the address it came from
    logic [31:0]   r_entry_pc    [DEPTH];
    logic [31:0]   r_entry_instr [DEPTH];

    logic          w_pop;
    logic          w_push;
    logic          w_nonempty;
    logic [31:0]   w_head_pc;
    logic [31:0]   w_head_instr;

    // Handshake decode: redirect suppresses both push and pop; a full queue
    // may still accept the new word when the head leaves in the same cycle.
    always_comb begin
        w_nonempty = 1'b0;
        w_pop      = 1'b0;
        w_push     = 1'b0;
        if (r_count != {CW{1'b0}}) begin
            w_nonempty = 1'b1;
        end else begin
            w_nonempty = 1'b0;
        end
        if (redirect) begin
            w_pop  = 1'b0;
            w_push = 1'b0;
        end else begin
            w_pop  = w_nonempty & dec_ready;
            w_push = (r_count < FULL_C) | w_pop;
        end
    end

    // Head view for decode; zeros while the queue is empty
    always_comb begin
        w_head_pc    = 32'h0000_0000;
        w_head_instr = 32'h0000_0000;
        if (w_nonempty) begin
            w_head_pc    = r_entry_pc[r_rd_ptr];
            w_head_instr = r_entry_instr[r_rd_ptr];
        end else begin
            w_head_pc    = 32'h0000_0000;
            w_head_instr = 32'h0000_0000;
        end
    end

    assign imem_a      = {r_pc[31:2], 2'b00};
    assign dec_valid   = w_nonempty;
    assign dec_pc      = w_head_pc;
    assign dec_instr   = w_head_instr;
    assign dec_pcplus8 = w_head_pc + 32'd8;
    assign count       = r_count;

    // Fetch PC, FIFO pointers, occupancy and entry capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc     <= {RESET_PC[31:2], 2'b00};
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_entry_pc[i]    <= 32'h0000_0000;
                r_entry_instr[i] <= 32'h0000_0000;
            end
        end else if (redirect) begin
            // Flush: stale entries are simply abandoned by zeroing the pointers
            r_pc     <= {redirect_pc[31:2], 2'b00};
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_entry_pc[r_wr_ptr]    <= imem_a;
                r_entry_instr[r_wr_ptr] <= imem_rd;
                // Wraps from FFFF_FFFC to 0 naturally
                r_pc                    <= r_pc + 32'd4;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end else begin
                r_pc     <= r_pc;
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic [31:0] imem_a, imem_rd, dec_instr, dec_pc, dec_pcplus8;
    logic        dec_valid;
    logic [2:0]  count;

    // Second instance exercising a reset PC near the top of the address space
    logic [31:0] imem_a2, imem_rd2, dec_instr2, dec_pc2, dec_pcplus82;
    logic        dec_valid2;
    logic [2:0]  count2;

    // Memory image: word at byte address a is (a/4)+100
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'd100;
    endfunction

    assign imem_rd  = mem_word(imem_a);
    assign imem_rd2 = mem_word(imem_a2);

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .reset(reset), .imem_a(imem_a), .imem_rd(imem_rd),
        .redirect(redirect), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .dec_pcplus8(dec_pcplus8), .count(count)
    );

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC2)) u_dut2 (
        .clk(clk), .reset(reset), .imem_a(imem_a2), .imem_rd(imem_rd2),
        .redirect(1'b0), .redirect_pc(32'h0), .dec_ready(1'b1),
        .dec_valid(dec_valid2), .dec_instr(dec_instr2), .dec_pc(dec_pc2),
        .dec_pcplus8(dec_pcplus82), .count(count2)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: stimulus pushes each redirect target; the monitor expects
    // the delivered stream to be consecutive word addresses from the latest
    // origin (reset PC or redirect target), each carrying its memory word.
    logic [31:0] redir_q[$];
    logic [31:0] exp_pc = 32'h0;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            exp_pc = 32'h0;
        end else begin
            check("sb_valid_vs_count", {31'b0, dec_valid}, {31'b0, (count != 3'd0)});
            check("sb_count_bound", {31'b0, (count <= 3'd4)}, 32'd1);
            check("sb_align", {30'b0, imem_a[1:0]}, 32'd0);
            if (dec_valid) begin
                check("sb_instr", dec_instr, mem_word(dec_pc));
                check("sb_pcplus8", dec_pcplus8, dec_pc + 32'd8);
            end else begin
                check("sb_empty_pc", dec_pc, 32'd0);
                check("sb_empty_instr", dec_instr, 32'd0);
                check("sb_empty_pcplus8", dec_pcplus8, 32'd8);
            end
            if (redirect) begin
                if (redir_q.size() == 0) begin
                    check("sb_redirect_queue", 32'd0, 32'd1);
                end else begin
                    exp_pc = redir_q.pop_front();
                end
            end else if (dec_valid) begin
                check("sb_order", dec_pc, exp_pc);
                if (dec_ready) exp_pc = exp_pc + 32'd4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        redir_q.push_back({pc[31:2], 2'b00});
        tick();
    endtask

    initial begin
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        dec_ready   = 1'b1;

        // 1: reset state, then streaming one instruction per cycle
        tick(); tick();
        check("rst_valid", {31'b0, dec_valid}, 32'd0);
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_imem_a", imem_a, 32'h0);
        check("rst_pcplus8", dec_pcplus8, 32'd8);
        check("rst_imem_a2", imem_a2, RPC2);
        reset = 1'b1;
        tick();
        check("t1_valid", {31'b0, dec_valid}, 32'd1);
        check("t1_pc0", dec_pc, 32'h0);
        check("t1_instr0", dec_instr, 32'd100);
        check("t5_pc0", dec_pc2, 32'hFFFF_FFF8);
        tick();
        check("t1_pc1", dec_pc, 32'h4);
        check("t1_instr1", dec_instr, 32'd101);
        check("t5_pc1", dec_pc2, 32'hFFFF_FFFC);
        tick();
        check("t5_pc2", dec_pc2, 32'h0);
        tick();
        check("t5_pc3", dec_pc2, 32'h4);
        repeat (3) tick();

        // 2: stall saturates the queue, then drains with no gap
        reset = 1'b0;
        dec_ready = 1'b0;
        tick();
        reset = 1'b1;
        repeat (10) tick();
        check("t2_count_full", {29'b0, count}, 32'd4);
        check("t2_imem_hold", imem_a, 32'h10);
        check("t2_head_hold", dec_pc, 32'h0);
        dec_ready = 1'b1;
        tick();
        check("t2_pop1", dec_pc, 32'h4);
        check("t2_count_steady", {29'b0, count}, 32'd4);
        repeat (3) tick();
        check("t2_follow", dec_pc, 32'h10);
        check("t2_count_steady2", {29'b0, count}, 32'd4);

        // 3: redirect from a full queue
        dec_ready = 1'b0;
        repeat (5) tick();
        do_redirect(32'h203);
        redirect = 1'b0;
        check("t3_count", {29'b0, count}, 32'd0);
        check("t3_valid", {31'b0, dec_valid}, 32'd0);
        check("t3_imem_a", imem_a, 32'h200);
        tick();
        check("t3_valid2", {31'b0, dec_valid}, 32'd1);
        check("t3_head", dec_pc, 32'h200);

        // 4: redirect wins over pop; back-to-back redirects
        tick();
        dec_ready = 1'b1;
        do_redirect(32'h300);
        check("t4_nopop_count", {29'b0, count}, 32'd0);
        do_redirect(32'h40);
        do_redirect(32'h80);
        do_redirect(32'hC0);
        redirect = 1'b0;
        check("t4_imem_a", imem_a, 32'hC0);
        check("t4_count", {29'b0, count}, 32'd0);
        check("t4_valid", {31'b0, dec_valid}, 32'd0);
        tick();
        check("t4_head", dec_pc, 32'hC0);
        check("t4_valid2", {31'b0, dec_valid}, 32'd1);

        // 6: asynchronous reset in mid-cycle with three entries queued
        dec_ready = 1'b0;
        do_redirect(32'h500);
        redirect = 1'b0;
        repeat (3) tick();
        check("t6_count3", {29'b0, count}, 32'd3);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("t6_async_valid", {31'b0, dec_valid}, 32'd0);
        check("t6_async_count", {29'b0, count}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        check("t6_restart_pc", dec_pc, 32'h0);
        check("t6_restart_valid", {31'b0, dec_valid}, 32'd1);

        // Random: phases of different decode back-pressure with random redirects
        for (int i = 0; i < 3000; i++) begin
            int mode;
            mode = (i / 50) % 3;
            case (mode)
                0:       dec_ready = 1'b1;
                1:       dec_ready = ($urandom % 2) == 0;
                default: dec_ready = ($urandom % 8) == 0;
            endcase
            if (($urandom % 24) == 0) begin
                redirect_pc = $urandom;
                redirect    = 1'b1;
                redir_q.push_back({redirect_pc[31:2], 2'b00});
            end else begin
                redirect = 1'b0;
            end
            tick();
        end
        redirect  = 1'b0;
        dec_ready = 1'b1;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
